// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe: stage-0 inputs and last-stage outputs.
// The producer side uses the master modport and the pipeline uses the slave modport.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] i_d;
  logic             i_vld;
  logic             i_en;
  logic             i_flush;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_qb;
  logic             o_vld;
  logic [CW-1:0]    o_cnt;

  modport master (
    output i_d, i_vld, i_en, i_flush,
    input  o_q, o_qb, o_vld, o_cnt
  );

  modport slave (
    input  i_d, i_vld, i_en, i_flush,
    output o_q, o_qb, o_vld, o_cnt
  );
endinterface

// File: rtl/dff_pipe.sv
// DEPTH-stage enabled register pipeline with per-stage valid bits, flush,
// and a registered count of the stages that currently hold valid data.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic     clk,
  input  logic     reset_n,
  dff_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q    [DEPTH];
  logic [WIDTH-1:0] data_d    [DEPTH];
  logic [WIDTH-1:0] stage_src [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] vld_src;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Source of each stage when the pipeline advances: the input for stage 0,
  // the previous stage otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_src[gi] = bus.i_d;
        assign vld_src[gi]   = bus.i_vld;
      end else begin : g_body
        assign stage_src[gi] = data_q[gi-1];
        assign vld_src[gi]   = vld_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    // Data follows i_en even during a flush; flush only kills the valid bits.
    if (bus.i_en) begin
      data_d = stage_src;
    end
    if (bus.i_flush) begin
      vld_d = '0;
      cnt_d = '0;
    end else if (bus.i_en) begin
      vld_d = vld_src;
      cnt_d = cnt_q + CW'(bus.i_vld) - CW'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.o_q   = data_q[DEPTH-1];
  assign bus.o_qb  = ~data_q[DEPTH-1];
  assign bus.o_vld = vld_q[DEPTH-1];
  assign bus.o_cnt = cnt_q;
endmodule

// File: tb/tb_dff_pipe.sv
// Directed and randomized checks of dff_pipe (WIDTH=8, DEPTH=3, RST_VAL=8'hA5)
// against a behavioural stage model and a scoreboard of valid input words.
module tb_dff_pipe;
  logic clk;
  logic reset_n;
  logic clk_run;

  dff_pipe_if #(.WIDTH(8), .DEPTH(3)) bus ();

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int         n_vec;
  int         n_err;
  logic [7:0] m_d [3];
  logic [2:0] m_v;
  logic [7:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_d[k] = 8'hA5;
    m_v = '0;
    sb.delete();
  endtask

  task automatic check_outputs();
    logic [7:0] qb_exp;
    qb_exp = ~m_d[2];
    chk("o_q", 32'(bus.o_q), 32'(m_d[2]));
    chk("o_qb", 32'(bus.o_qb), 32'(qb_exp));
    chk("o_vld", 32'(bus.o_vld), 32'(m_v[2]));
    chk("o_cnt", 32'(bus.o_cnt), 32'(m_v[0]) + 32'(m_v[1]) + 32'(m_v[2]));
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic [7:0] d, input logic vl, input logic en, input logic fl);
    logic [7:0] exp_q;
    @(negedge clk);
    bus.i_d     = d;
    bus.i_vld   = vl;
    bus.i_en    = en;
    bus.i_flush = fl;
    @(posedge clk);
    #1;
    if (en) begin
      m_d[2] = m_d[1];
      m_d[1] = m_d[0];
      m_d[0] = d;
    end
    if (fl) begin
      m_v = '0;
      sb.delete();
    end else if (en) begin
      m_v = {m_v[1:0], vl};
      if (vl) sb.push_back(d);
      if (m_v[2]) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL sb_empty: observed valid output expected none pending");
        end else begin
          exp_q = sb.pop_front();
          chk("sb_q", 32'(bus.o_q), 32'(exp_q));
        end
      end
    end
    $display("step d=%02h vld=%0b en=%0b flush=%0b -> q=%02h vld=%0b cnt=%0d",
             d, vl, en, fl, bus.o_q, bus.o_vld, bus.o_cnt);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clk     = 1'b0;
    clk_run = 1'b0;
    reset_n = 1'b1;
    bus.i_d     = 8'($urandom);
    bus.i_vld   = 1'($urandom);
    bus.i_en    = 1'($urandom);
    bus.i_flush = 1'($urandom);

    // Asynchronous reset with the clock stopped.
    #3 reset_n = 1'b0;
    #1;
    chk("rst_q", 32'(bus.o_q), 32'h A5);
    chk("rst_qb", 32'(bus.o_qb), 32'h5A);
    chk("rst_vld", 32'(bus.o_vld), 32'h0);
    chk("rst_cnt", 32'(bus.o_cnt), 32'h0);
    model_reset();
    bus.i_en    = 1'b0;
    bus.i_flush = 1'b0;
    clk_run     = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming
    step(8'h01, 1'b1, 1'b1, 1'b0); chk("stream_cnt1", 32'(bus.o_cnt), 1);
    step(8'h02, 1'b1, 1'b1, 1'b0); chk("stream_cnt2", 32'(bus.o_cnt), 2);
    step(8'h03, 1'b1, 1'b1, 1'b0); chk("stream_cnt3", 32'(bus.o_cnt), 3);
    chk("stream_q1", 32'(bus.o_q), 32'h01);
    chk("stream_vld1", 32'(bus.o_vld), 1);
    step(8'h04, 1'b1, 1'b1, 1'b0); chk("stream_cnt4", 32'(bus.o_cnt), 3);
    chk("stream_q2", 32'(bus.o_q), 32'h02);
    step(8'h05, 1'b1, 1'b1, 1'b0); chk("stream_q3", 32'(bus.o_q), 32'h03);

    // Flush of a full pipe with valid input offered
    step(8'hEE, 1'b1, 1'b1, 1'b1);
    chk("flush_vld", 32'(bus.o_vld), 0);
    chk("flush_cnt", 32'(bus.o_cnt), 0);

    // Stall
    step(8'h11, 1'b1, 1'b1, 1'b0);
    step(8'h22, 1'b1, 1'b1, 1'b0);
    chk("stall_cnt_pre", 32'(bus.o_cnt), 2);
    for (int i = 0; i < 5; i++) begin
      step(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      chk("stall_q", 32'(bus.o_q), 32'hEE);
      chk("stall_cnt", 32'(bus.o_cnt), 2);
    end
    step(8'h00, 1'b0, 1'b1, 1'b0);
    chk("stall_resume_q", 32'(bus.o_q), 32'h11);
    chk("stall_resume_vld", 32'(bus.o_vld), 1);

    // Bubbles
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'hA1, 1'b1, 1'b1, 1'b0);
    step(8'hA2, 1'b0, 1'b1, 1'b0);
    step(8'hA3, 1'b1, 1'b1, 1'b0); chk("bubble_vld3", 32'(bus.o_vld), 1);
    step(8'hA4, 1'b0, 1'b1, 1'b0); chk("bubble_vld4", 32'(bus.o_vld), 0);
    step(8'hA5, 1'b0, 1'b1, 1'b0); chk("bubble_vld5", 32'(bus.o_vld), 1);
    chk("bubble_q5", 32'(bus.o_q), 32'hA3);

    // Mid-stream reset between clock edges
    step(8'h00, 1'b0, 1'b1, 1'b1);
    step(8'h33, 1'b1, 1'b1, 1'b0);
    step(8'h44, 1'b1, 1'b1, 1'b0);
    chk("mid_cnt_pre", 32'(bus.o_cnt), 2);
    bus.i_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(bus.o_q), 32'hA5);
    chk("mid_rst_qb", 32'(bus.o_qb), 32'h5A);
    chk("mid_rst_vld", 32'(bus.o_vld), 0);
    chk("mid_rst_cnt", 32'(bus.o_cnt), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h55, 1'b1, 1'b1, 1'b0);
    step(8'h66, 1'b1, 1'b1, 1'b0);
    step(8'h77, 1'b1, 1'b1, 1'b0);
    chk("mid_resume_q", 32'(bus.o_q), 32'h55);
    chk("mid_resume_cnt", 32'(bus.o_cnt), 3);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
